nclic_dispatch: RTL and testbench

- Parametrised nested-interrupt dispatch unit for the hippo core: holds per-line config (priority, enable, pending), edge-detects interrupt lines, arbitrates the highest eligible line, and hands it to the core over a take/ack handshake.
- Tracks the running priority and a bounded nesting stack, so a strictly higher-priority interrupt preempts the current one and mret restores the previous level.
- Sits between the peripheral irq lines and the core's CSR/trap logic. Config is read and written through a CSR-side port.

---
 rtl/nclic_dispatch_pkg.sv | 36 +++
 rtl/nclic_dispatch_prio_stack.sv | 80 ++++++++
 rtl/nclic_dispatch.sv | 201 ++++++++++++++++++++
 tb/tb_nclic_dispatch.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nclic_dispatch_pkg.sv
// ----------------------------------------------------------------------------
// nclic_dispatch_pkg
// Shared sizing constants, types and helpers for the nested interrupt
// dispatch unit (nclic_dispatch) and its priority stack (nclic_prio_stack).
//   IntAmount  : number of interrupt lines
//   Priorities : number of priority levels (level 0 = thread mode, never taken)
//   NestDepth  : maximum number of simultaneously active handlers
// ----------------------------------------------------------------------------
package nclic_dispatch_pkg;

    localparam int IntAmount   = 8;
    localparam int Priorities  = 8;
    localparam int NestDepth   = 4;

    localparam int IntIdxWidth = (IntAmount > 1) ? $clog2(IntAmount) : 1;
    localparam int PrioWidth   = (Priorities > 1) ? $clog2(Priorities) : 1;
    localparam int NestWidth   = $clog2(NestDepth + 1);

    typedef logic [IntIdxWidth-1:0] IntIdx;
    typedef logic [PrioWidth-1:0]   IntPrio;
    typedef logic [NestWidth-1:0]   NestLvl;

    // Per-line configuration as seen on the CSR-side port.
    typedef struct packed {
        IntPrio prio;
        logic   enabled;
        logic   pending;
    } int_config_t;

    // A line may be offered when it is pending, enabled and strictly above
    // the running priority. The nesting-room condition is applied by the caller.
    function automatic logic line_eligible(input int_config_t cfg, input IntPrio cur_prio);
        return cfg.pending && cfg.enabled && (cfg.prio > cur_prio);
    endfunction

endpackage

// File: rtl/nclic_dispatch_prio_stack.sv
// ----------------------------------------------------------------------------
// nclic_prio_stack
// LIFO of saved running priorities, one entry per active nested handler.
// Push while full and pop while empty are silently ignored; the caller owns
// the policy for those cases.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : store i_data on top of the stack
//   i_pop      : discard the top entry
//   i_data     : priority to push
//   o_top      : current top entry (0 when empty)
//   o_full     : stack holds Depth entries
//   o_empty    : stack holds no entries
//   o_count    : number of entries held
// ----------------------------------------------------------------------------
module nclic_prio_stack
    import nclic_dispatch_pkg::*;
#(
    parameter int Depth = NestDepth
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  IntPrio                       i_data,
    output IntPrio                       o_top,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(Depth+1)-1:0]   o_count
);

    localparam int CntW = $clog2(Depth + 1);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    IntPrio            r_mem [Depth];
    logic [CntW-1:0]   r_count;
    logic [CntW-1:0]   w_count_dec;
    logic [PtrW-1:0]   w_wr_ptr;
    logic [PtrW-1:0]   w_rd_ptr;
    logic              w_full;
    logic              w_empty;

    assign w_full      = (r_count == CntW'(Depth));
    assign w_empty     = (r_count == CntW'(0));
    assign w_count_dec = r_count - CntW'(1);
    // The write slot is the current count; it always fits while not full.
    assign w_wr_ptr    = r_count[PtrW-1:0];
    assign w_rd_ptr    = w_count_dec[PtrW-1:0];

    // Stack storage and occupancy counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            for (int i = 0; i < Depth; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_push && !w_full) begin
            r_mem[w_wr_ptr] <= i_data;
            r_count         <= r_count + CntW'(1);
        end else if (i_pop && !w_empty) begin
            r_count <= w_count_dec;
        end else begin
            r_count <= r_count;
        end
    end

    // Top-of-stack read, forced to zero when nothing is stored.
    always_comb begin
        o_top = '0;
        if (w_empty) begin
            o_top = '0;
        end else begin
            o_top = r_mem[w_rd_ptr];
        end
    end

    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule

// File: rtl/nclic_dispatch.sv
// ----------------------------------------------------------------------------
// nclic_dispatch
// Nested interrupt dispatch unit. Holds per-line config, edge-detects the
// irq lines into pending bits, arbitrates the highest eligible line and offers
// it to the core over a take/ack handshake. Tracks the running priority and a
// bounded nesting stack so that mret restores the preempted level.
//   clk, rst_n    : clock, asynchronous active-low reset
//   irq_i         : raw level interrupt lines (synchronous to clk)
//   cfg_we_i      : config write strobe
//   cfg_idx_i     : config line index (read and write)
//   cfg_wdata_i   : config write data {prio, enabled, pending}
//   cfg_rdata_o   : config of line cfg_idx_i (combinational)
//   take_o        : an interrupt is offered to the core
//   take_id_o     : offered line
//   take_prio_o   : priority of the offered line
//   take_ack_i    : core accepts the offer this cycle
//   ret_i         : handler exit (mret)
//   cur_prio_o    : running priority, 0 = thread mode
//   nest_level_o  : number of active handlers
//   err_o         : sticky error (ret on empty stack, or ack together with ret)
// ----------------------------------------------------------------------------
module nclic_dispatch
    import nclic_dispatch_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [IntAmount-1:0]   irq_i,
    input  logic                   cfg_we_i,
    input  IntIdx                  cfg_idx_i,
    input  int_config_t            cfg_wdata_i,
    output int_config_t            cfg_rdata_o,
    output logic                   take_o,
    output IntIdx                  take_id_o,
    output IntPrio                 take_prio_o,
    input  logic                   take_ack_i,
    input  logic                   ret_i,
    output IntPrio                 cur_prio_o,
    output NestLvl                 nest_level_o,
    output logic                   err_o
);

    logic [IntAmount-1:0] r_irq_q;
    int_config_t          r_cfg      [IntAmount];
    int_config_t          w_cfg_next [IntAmount];
    logic [IntAmount-1:0] w_edge;

    IntPrio               r_cur_prio;
    logic                 r_take;
    IntIdx                r_take_id;
    IntPrio               r_take_prio;
    logic                 r_err;

    logic                 w_accept;
    logic                 w_ret;
    logic                 w_err_evt;

    logic                 w_found;
    IntIdx                w_best_id;
    IntPrio               w_best_prio;

    IntPrio               w_stack_top;
    logic                 w_stack_full;
    logic                 w_stack_empty;
    NestLvl               w_nest;

    assign w_edge    = irq_i & ~r_irq_q;
    // An ack only counts against a live offer; ack and ret together cancel.
    assign w_accept  = take_ack_i & r_take & ~ret_i;
    assign w_ret     = ret_i & ~take_ack_i;
    assign w_err_evt = (take_ack_i & ret_i) | (w_ret & w_stack_empty);

    // Saved-priority stack; its occupancy is the nesting level.
    nclic_prio_stack #(
        .Depth   (NestDepth)
    ) u_prio_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_accept),
        .i_pop   (w_ret),
        .i_data  (r_cur_prio),
        .o_top   (w_stack_top),
        .o_full  (w_stack_full),
        .o_empty (w_stack_empty),
        .o_count (w_nest)
    );

    // Next config per line: CSR write, then hardware edge sets pending,
    // then the accept clear has the last word.
    always_comb begin
        for (int k = 0; k < IntAmount; k++) begin
            w_cfg_next[k] = r_cfg[k];
            if (cfg_we_i && (cfg_idx_i == IntIdx'(k))) begin
                w_cfg_next[k] = cfg_wdata_i;
            end else begin
                w_cfg_next[k] = r_cfg[k];
            end
            if (w_edge[k]) begin
                w_cfg_next[k].pending = 1'b1;
            end else begin
                w_cfg_next[k].pending = w_cfg_next[k].pending;
            end
            if (w_accept && (r_take_id == IntIdx'(k))) begin
                w_cfg_next[k].pending = 1'b0;
            end else begin
                w_cfg_next[k].pending = w_cfg_next[k].pending;
            end
        end
    end

    // Config storage and irq sample used for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_q <= '0;
            for (int k = 0; k < IntAmount; k++) begin
                r_cfg[k] <= '0;
            end
        end else begin
            r_irq_q <= irq_i;
            for (int k = 0; k < IntAmount; k++) begin
                r_cfg[k] <= w_cfg_next[k];
            end
        end
    end

    // Arbitration: strict '>' while scanning upward keeps the lowest index on ties.
    always_comb begin
        w_found     = 1'b0;
        w_best_id   = '0;
        w_best_prio = '0;
        for (int k = 0; k < IntAmount; k++) begin
            if (!w_stack_full && line_eligible(r_cfg[k], r_cur_prio) &&
                (r_cfg[k].prio > w_best_prio)) begin
                w_found     = 1'b1;
                w_best_id   = IntIdx'(k);
                w_best_prio = r_cfg[k].prio;
            end else begin
                w_found     = w_found;
            end
        end
    end

    // Offer register; id/prio hold their last value whenever nothing is offered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_take      <= 1'b0;
            r_take_id   <= '0;
            r_take_prio <= '0;
        end else if (w_accept) begin
            // Arbitration still sees the pre-accept pending bit this cycle.
            r_take      <= 1'b0;
        end else if (w_found) begin
            r_take      <= 1'b1;
            r_take_id   <= w_best_id;
            r_take_prio <= w_best_prio;
        end else begin
            r_take      <= 1'b0;
        end
    end

    // Running priority: raised on accept, restored from the stack on return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_prio <= '0;
        end else if (w_accept) begin
            r_cur_prio <= r_take_prio;
        end else if (w_ret && !w_stack_empty) begin
            r_cur_prio <= w_stack_top;
        end else begin
            r_cur_prio <= r_cur_prio;
        end
    end

    // Sticky protocol error flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_err_evt) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end

    // CSR-side combinational config read; out-of-range indices read as zero.
    always_comb begin
        cfg_rdata_o = '0;
        if ({1'b0, cfg_idx_i} < (IntIdxWidth + 1)'(IntAmount)) begin
            cfg_rdata_o = r_cfg[cfg_idx_i];
        end else begin
            cfg_rdata_o = '0;
        end
    end

    assign take_o       = r_take;
    assign take_id_o    = r_take_id;
    assign take_prio_o  = r_take_prio;
    assign cur_prio_o   = r_cur_prio;
    assign nest_level_o = w_nest;
    assign err_o        = r_err;

endmodule

// File: tb/tb_nclic_dispatch.sv
// ----------------------------------------------------------------------------
// tb_nclic_dispatch
// Directed self-checking bench for nclic_dispatch. Inputs change 1 time unit
// after the rising edge; outputs are sampled at the same point.
// ----------------------------------------------------------------------------
module tb_nclic_dispatch;
    import nclic_dispatch_pkg::*;

    logic                 clk;
    logic                 rst_n;
    logic [IntAmount-1:0] irq;
    logic                 cfg_we;
    IntIdx                cfg_idx;
    int_config_t          cfg_wdata;
    int_config_t          cfg_rdata;
    logic                 take;
    IntIdx                take_id;
    IntPrio               take_prio;
    logic                 take_ack;
    logic                 ret;
    IntPrio               cur_prio;
    NestLvl               nest_level;
    logic                 err;

    int n_checks;
    int n_errors;

    nclic_dispatch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_i        (irq),
        .cfg_we_i     (cfg_we),
        .cfg_idx_i    (cfg_idx),
        .cfg_wdata_i  (cfg_wdata),
        .cfg_rdata_o  (cfg_rdata),
        .take_o       (take),
        .take_id_o    (take_id),
        .take_prio_o  (take_prio),
        .take_ack_i   (take_ack),
        .ret_i        (ret),
        .cur_prio_o   (cur_prio),
        .nest_level_o (nest_level),
        .err_o        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cfgv(input int prio, input bit en, input bit pend);
        int_config_t c;
        c.prio    = IntPrio'(prio);
        c.enabled = en;
        c.pending = pend;
        return 32'(c);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_wr(input int idx, input int prio, input bit en, input bit pend);
        cfg_we            = 1'b1;
        cfg_idx           = IntIdx'(idx);
        cfg_wdata.prio    = IntPrio'(prio);
        cfg_wdata.enabled = en;
        cfg_wdata.pending = pend;
        step();
        cfg_we            = 1'b0;
    endtask

    task automatic check_cfg(input string tag, input int idx, input int prio, input bit en, input bit pend);
        cfg_idx = IntIdx'(idx);
        #1;
        check_eq(tag, 32'(cfg_rdata), cfgv(prio, en, pend));
    endtask

    // One-cycle pulse on a line, then one more edge so the offer is visible.
    task automatic fire(input int k);
        irq[k] = 1'b1;
        step();
        irq[k] = 1'b0;
        step();
    endtask

    task automatic do_ack();
        take_ack = 1'b1;
        step();
        take_ack = 1'b0;
    endtask

    task automatic do_ret();
        ret = 1'b1;
        step();
        ret = 1'b0;
    endtask

    task automatic check_offer(input string tag, input bit exp_take, input int exp_id, input int exp_prio);
        check_eq({tag, ".take"}, 32'(take), 32'(exp_take));
        if (exp_take) begin
            check_eq({tag, ".id"},   32'(take_id),   32'(exp_id));
            check_eq({tag, ".prio"}, 32'(take_prio), 32'(exp_prio));
        end else begin
            n_checks = n_checks;
        end
    endtask

    task automatic check_level(input string tag, input int exp_cur, input int exp_nest);
        check_eq({tag, ".cur"},  32'(cur_prio),   32'(exp_cur));
        check_eq({tag, ".nest"}, 32'(nest_level), 32'(exp_nest));
    endtask

    initial begin
        int lines [4];
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        irq       = '0;
        cfg_we    = 1'b0;
        cfg_idx   = '0;
        cfg_wdata = '0;
        take_ack  = 1'b0;
        ret       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_offer("rst", 1'b0, 0, 0);
        check_eq("rst.id", 32'(take_id), 32'd0);
        check_eq("rst.prio", 32'(take_prio), 32'd0);
        check_level("rst", 0, 0);
        check_eq("rst.err", 32'(err), 32'd0);
        check_cfg("rst.cfg3", 3, 0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();

        // Basic path: line 3 prio 2.
        cfg_wr(3, 2, 1'b1, 1'b0);
        check_cfg("t1.cfg", 3, 2, 1'b1, 1'b0);
        irq[3] = 1'b1;
        step();
        check_cfg("t1.pend", 3, 2, 1'b1, 1'b1);
        check_offer("t1.nooffer", 1'b0, 0, 0);
        irq[3] = 1'b0;
        step();
        check_offer("t1.offer", 1'b1, 3, 2);
        do_ack();
        check_offer("t1.acked", 1'b0, 0, 0);
        check_level("t1.acked", 2, 1);
        check_cfg("t1.clr", 3, 2, 1'b1, 1'b0);
        step();
        check_offer("t1.idle", 1'b0, 0, 0);

        // Preemption only by strictly higher priority; tail chain after pops.
        cfg_wr(5, 2, 1'b1, 1'b0);
        cfg_wr(6, 5, 1'b1, 1'b0);
        fire(5);
        check_offer("t2.eqprio", 1'b0, 0, 0);
        fire(6);
        check_offer("t2.pre", 1'b1, 6, 5);
        do_ack();
        check_level("t2.nest2", 5, 2);
        do_ret();
        check_level("t2.ret1", 2, 1);
        step();
        check_offer("t2.held", 1'b0, 0, 0);
        check_cfg("t2.pend5", 5, 2, 1'b1, 1'b1);
        do_ret();
        check_level("t2.ret2", 0, 0);
        step();
        check_offer("t2.tail", 1'b1, 5, 2);
        do_ack();
        do_ret();

        // Equal priorities: lowest index first.
        cfg_wr(1, 3, 1'b1, 1'b0);
        cfg_wr(4, 3, 1'b1, 1'b0);
        irq[1] = 1'b1;
        irq[4] = 1'b1;
        step();
        irq = '0;
        step();
        check_offer("t3.first", 1'b1, 1, 3);
        do_ack();
        do_ret();
        check_offer("t3.gap", 1'b0, 0, 0);
        step();
        check_offer("t3.second", 1'b1, 4, 3);
        do_ack();
        do_ret();

        // Fill the nesting stack with priorities 1..4, then a prio-7 arrival.
        cfg_wr(0, 1, 1'b1, 1'b0);
        cfg_wr(1, 2, 1'b1, 1'b0);
        cfg_wr(3, 3, 1'b1, 1'b0);
        cfg_wr(4, 4, 1'b1, 1'b0);
        cfg_wr(7, 7, 1'b1, 1'b0);
        lines = '{0, 1, 3, 4};
        for (int i = 0; i < 4; i++) begin
            fire(lines[i]);
            check_offer($sformatf("t4.nest%0d", i), 1'b1, lines[i], i + 1);
            do_ack();
        end
        check_level("t4.full", 4, 4);
        fire(7);
        check_offer("t4.blocked", 1'b0, 0, 0);
        step();
        check_offer("t4.blocked2", 1'b0, 0, 0);
        do_ret();
        check_level("t4.ret", 3, 3);
        step();
        check_offer("t4.room", 1'b1, 7, 7);
        do_ack();
        check_level("t4.top", 7, 4);
        repeat (4) do_ret();
        check_level("t4.unwound", 0, 0);

        // Disabled line still latches pending; enabling it raises the offer.
        cfg_wr(2, 6, 1'b0, 1'b0);
        fire(2);
        check_cfg("t6.pend", 2, 6, 1'b0, 1'b1);
        check_offer("t6.disabled", 1'b0, 0, 0);
        cfg_wr(2, 6, 1'b1, 1'b1);
        check_offer("t6.lat1", 1'b0, 0, 0);
        step();
        check_offer("t6.enabled", 1'b1, 2, 6);
        do_ack();
        check_level("t6.acked", 6, 1);
        do_ret();
        // Hardware edge beats a same-cycle write that clears pending.
        cfg_we            = 1'b1;
        cfg_idx           = IntIdx'(2);
        cfg_wdata.prio    = IntPrio'(6);
        cfg_wdata.enabled = 1'b0;
        cfg_wdata.pending = 1'b0;
        irq[2]            = 1'b1;
        step();
        cfg_we = 1'b0;
        irq[2] = 1'b0;
        check_cfg("t6.setwins", 2, 6, 1'b0, 1'b1);

        // Error cases.
        check_eq("t5.noerr", 32'(err), 32'd0);
        do_ret();
        check_eq("t5.err", 32'(err), 32'd1);
        check_level("t5.emptyret", 0, 0);
        fire(4);
        check_offer("t5.offer", 1'b1, 4, 4);
        take_ack = 1'b1;
        ret      = 1'b1;
        step();
        take_ack = 1'b0;
        ret      = 1'b0;
        check_level("t5.both", 0, 0);
        check_eq("t5.errsticky", 32'(err), 32'd1);
        check_cfg("t5.pendkept", 4, 4, 1'b1, 1'b1);
        check_offer("t5.stilloffered", 1'b1, 4, 4);

        // Asynchronous reset mid-operation.
        rst_n = 1'b0;
        #1;
        check_offer("rst2", 1'b0, 0, 0);
        check_eq("rst2.id", 32'(take_id), 32'd0);
        check_eq("rst2.prio", 32'(take_prio), 32'd0);
        check_level("rst2", 0, 0);
        check_eq("rst2.err", 32'(err), 32'd0);
        check_cfg("rst2.cfg4", 4, 0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
